ledmatrix_ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port LED-matrix frame-buffer RAM (32-bit words, 51200 deep, 1-cycle read latency) between the CPU Avalon-MM path and the display scan engine. It sits between the Avalon interconnect and the RAM's s1 port. It grants at most one access per cycle and gives the scan engine priority, with a starvation guard for the CPU. It returns read data with per-requester valid strobes.

---
 rtl/ledmatrix_pkg.sv | 24 ++
 rtl/ledmatrix_arb_grant.sv | 57 +++++
 rtl/ledmatrix_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ledmatrix_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ledmatrix_pkg.sv
// Shared constants and types for the LED-matrix frame-buffer RAM arbiter.
package ledmatrix_pkg;

    // Default geometry of the frame-buffer RAM.
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int DEPTH      = 51200;

    // Default limit on consecutive cycles a pending CPU request may lose to scan.
    localparam int STARVE_MAX = 4;

    // Owner encoding carried in the read-return tag.
    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_SCAN = 1'b1;

    // Read-return tag captured at grant.
    // 'busy' marks a read in flight; when clear the tag means "none".
    typedef struct packed {
        logic busy;
        logic owner;
        logic oor;
    } ret_tag_t;

endpackage

// File: rtl/ledmatrix_arb_grant.sv
// Grant decision between CPU and scan, with a starvation guard for the CPU.
module ledmatrix_arb_grant
    import ledmatrix_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_pend_i,
    input  logic scan_pend_i,
    output logic cpu_grant_o,
    output logic scan_grant_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       starved;

    assign starved = (starve_cnt_q == LIMIT);

    // Scan wins ties unless the CPU has already lost LIMIT cycles in a row;
    // both grants are forced low while reset is asserted.
    always_comb begin
        cpu_grant_o  = 1'b0;
        scan_grant_o = 1'b0;
        if (!reset) begin
            cpu_grant_o  = cpu_pend_i & (~scan_pend_i | starved);
            scan_grant_o = scan_pend_i & ~cpu_grant_o;
        end
    end

    // Count consecutive lost cycles for a pending CPU request, saturating at LIMIT.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no
        // path through the block can infer a latch.
        starve_cnt_d = starve_cnt_q;
        if (!cpu_pend_i || cpu_grant_o) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ledmatrix_ram_arbiter.sv
// Shares the single-port frame-buffer RAM between the CPU Avalon-MM path and
// the display scan engine. Scan has priority; the CPU is protected from
// starvation. Read data returns one cycle after grant with per-owner strobes.
module ledmatrix_ram_arbiter
    import ledmatrix_pkg::*;
#(
    parameter int ADDR_W     = ledmatrix_pkg::ADDR_W,
    parameter int DATA_W     = ledmatrix_pkg::DATA_W,
    parameter int DEPTH      = ledmatrix_pkg::DEPTH,
    parameter int STARVE_MAX = ledmatrix_pkg::STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU Avalon-MM slave side
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    output logic                  cpu_waitrequest,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_readdatavalid,
    // Scan engine read port
    input  logic                  scan_req,
    input  logic [ADDR_W-1:0]     scan_address,
    output logic                  scan_gnt,
    output logic [DATA_W-1:0]     scan_rdata,
    output logic                  scan_rvalid,
    // RAM s1 port
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic cpu_pend;
    logic cpu_grant;
    logic scan_grant;
    logic cpu_oor;
    logic scan_oor;

    // Last driven RAM-side address/data, held while nobody is granted.
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    ret_tag_t          tag_q;
    ret_tag_t          tag_d;
    logic [DATA_W-1:0] ret_data;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] scan_rdata_q;

    assign cpu_pend = cpu_read | cpu_write;
    assign cpu_oor  = ({1'b0, cpu_address}  >= DEPTH_L);
    assign scan_oor = ({1'b0, scan_address} >= DEPTH_L);

    ledmatrix_arb_grant #(
        .STARVE_LIMIT (STARVE_MAX)
    ) u_grant (
        .clk          (clk),
        .reset        (reset),
        .cpu_pend_i   (cpu_pend),
        .scan_pend_i  (scan_req),
        .cpu_grant_o  (cpu_grant),
        .scan_grant_o (scan_grant)
    );

    assign cpu_waitrequest = cpu_pend & ~cpu_grant;
    assign scan_gnt        = scan_req & scan_grant;

    // RAM-side mux: drive the granted access this cycle and build its return tag.
    // A CPU read+write combination is a write and produces no return tag.
    always_comb begin
        ram_address    = addr_q;
        ram_writedata  = wdata_q;
        ram_byteenable = be_q;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        tag_d          = '0;
        if (cpu_grant) begin
            ram_address    = cpu_address;
            ram_writedata  = cpu_writedata;
            ram_byteenable = cpu_write ? cpu_byteenable : {BE_W{1'b1}};
            ram_chipselect = ~cpu_oor;
            ram_write      = cpu_write & ~cpu_oor;
            if (!cpu_write) begin
                tag_d = '{busy: 1'b1, owner: OWN_CPU, oor: cpu_oor};
            end
        end else if (scan_grant) begin
            ram_address    = scan_address;
            ram_byteenable = {BE_W{1'b1}};
            ram_chipselect = ~scan_oor;
            tag_d          = '{busy: 1'b1, owner: OWN_SCAN, oor: scan_oor};
        end
    end

    // Hold the RAM-side address, data and lanes of the last granted access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (cpu_grant || scan_grant) begin
            addr_q  <= ram_address;
            wdata_q <= ram_writedata;
            be_q    <= ram_byteenable;
        end
    end

    // Return tag register; async reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Readback routing: out-of-range reads return zero; the owner sees fresh data
    // and its strobe, the other side keeps its last value.
    always_comb begin
        ret_data          = tag_q.oor ? '0 : ram_readdata;
        cpu_readdatavalid = tag_q.busy & (tag_q.owner == OWN_CPU);
        scan_rvalid       = tag_q.busy & (tag_q.owner == OWN_SCAN);
        cpu_readdata      = cpu_readdatavalid ? ret_data : cpu_rdata_q;
        scan_rdata        = scan_rvalid       ? ret_data : scan_rdata_q;
    end

    // Remember the last returned data per requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            scan_rdata_q <= '0;
        end else begin
            cpu_rdata_q  <= cpu_readdata;
            scan_rdata_q <= scan_rdata;
        end
    end

endmodule

// File: tb/tb_ledmatrix_ram_arbiter.sv
// Directed self-checking bench for ledmatrix_ram_arbiter with a behavioural
// 1-cycle-latency frame-buffer RAM attached to the s1 port.
module tb_ledmatrix_ram_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_address;
    logic [3:0]  cpu_byteenable;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic        scan_req;
    logic [15:0] scan_address;
    logic        scan_gnt;
    logic [31:0] scan_rdata;
    logic        scan_rvalid;
    logic [15:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:51199];

    ledmatrix_ram_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_address       (cpu_address),
        .cpu_byteenable    (cpu_byteenable),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_writedata     (cpu_writedata),
        .cpu_waitrequest   (cpu_waitrequest),
        .cpu_readdata      (cpu_readdata),
        .cpu_readdatavalid (cpu_readdatavalid),
        .scan_req          (scan_req),
        .scan_address      (scan_address),
        .scan_gnt          (scan_gnt),
        .scan_rdata        (scan_rdata),
        .scan_rvalid       (scan_rvalid),
        .ram_address       (ram_address),
        .ram_byteenable    (ram_byteenable),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_writedata     (ram_writedata),
        .ram_readdata      (ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer RAM: byte-lane writes, registered read data.
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then let combinational outputs settle.
    task automatic tick(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic sreq, input logic [15:0] sa);
        @(negedge clk);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        scan_req       = sreq;
        scan_address   = sa;
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 16'h0);
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        tick(1'b0, 1'b1, a, d, be, 1'b0, 16'h0);
    endtask

    initial begin
        ram_readdata = 32'h0;
        reset = 1'b1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_address = 16'h0010;
        cpu_writedata = 32'h0; cpu_byteenable = 4'hF;
        scan_req = 1'b1; scan_address = 16'h0000;
        #2;
        // Reset state with both requests present.
        check("rst_waitreq",  {31'h0, cpu_waitrequest},   32'h1);
        check("rst_scan_gnt", {31'h0, scan_gnt},          32'h0);
        check("rst_cs",       {31'h0, ram_chipselect},    32'h0);
        check("rst_wr",       {31'h0, ram_write},         32'h0);
        check("rst_cvalid",   {31'h0, cpu_readdatavalid}, 32'h0);
        check("rst_svalid",   {31'h0, scan_rvalid},       32'h0);
        check("rst_cdata",    cpu_readdata,               32'h0);
        check("rst_sdata",    scan_rdata,                 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();

        // Preload words used later.
        cpu_wr(16'h0100, 32'hCAFE0100, 4'hF);
        cpu_wr(16'h0101, 32'hCAFE0101, 4'hF);
        cpu_wr(16'h0200, 32'h5CA20200, 4'hF);
        for (int i = 0; i < 4; i++) cpu_wr(16'(i), 32'hA0000000 + 32'(i), 4'hF);

        // Full-word write then read back.
        cpu_wr(16'h0010, 32'hDEADBEEF, 4'hF);
        check("w1_waitreq", {31'h0, cpu_waitrequest}, 32'h0);
        check("w1_cs",      {31'h0, ram_chipselect},  32'h1);
        check("w1_wr",      {31'h0, ram_write},       32'h1);
        check("w1_be",      {28'h0, ram_byteenable},  32'hF);
        tick(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 16'h0);
        check("r1_waitreq", {31'h0, cpu_waitrequest},   32'h0);
        check("r1_wr",      {31'h0, ram_write},         32'h0);
        check("r1_be",      {28'h0, ram_byteenable},    32'hF);
        check("r1_novalid", {31'h0, cpu_readdatavalid}, 32'h0);
        idle();
        check("r1_valid",   {31'h0, cpu_readdatavalid}, 32'h1);
        check("r1_data",    cpu_readdata,               32'hDEADBEEF);
        idle();
        check("r1_pulse",   {31'h0, cpu_readdatavalid}, 32'h0);
        check("r1_hold",    cpu_readdata,               32'hDEADBEEF);
        check("idle_cs",    {31'h0, ram_chipselect},    32'h0);
        check("idle_addr",  {16'h0, ram_address},       32'h00000010);

        // Partial byte-lane write.
        cpu_wr(16'h0020, 32'h11223344, 4'hF);
        cpu_wr(16'h0020, 32'h000000AA, 4'h1);
        check("be1_be", {28'h0, ram_byteenable}, 32'h1);
        tick(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 1'b0, 16'h0);
        idle();
        check("be1_data", cpu_readdata, 32'h112233AA);

        // Read and write together: handled as a write, no return strobe.
        tick(1'b1, 1'b1, 16'h0030, 32'h00000055, 4'hF, 1'b0, 16'h0);
        check("rw_wr", {31'h0, ram_write}, 32'h1);
        idle();
        check("rw_novalid", {31'h0, cpu_readdatavalid}, 32'h0);

        // Starvation guard: scan held continuously against a CPU read.
        tick(1'b1, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1, 16'h0200);
        check("st_wait0", {31'h0, cpu_waitrequest}, 32'h1);
        check("st_sgnt0", {31'h0, scan_gnt},        32'h1);
        for (int i = 1; i < 4; i++) begin
            tick(1'b1, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1, 16'h0200);
            check($sformatf("st_wait%0d", i), {31'h0, cpu_waitrequest}, 32'h1);
            check($sformatf("st_sv%0d", i),   {31'h0, scan_rvalid},     32'h1);
        end
        tick(1'b1, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1, 16'h0200);
        check("st_grant",  {31'h0, cpu_waitrequest}, 32'h0);
        check("st_sgnt4",  {31'h0, scan_gnt},        32'h0);
        check("st_addr",   {16'h0, ram_address},     32'h00000100);
        check("st_sdata",  scan_rdata,               32'h5CA20200);
        // Counter restarted: a fresh CPU request loses four more cycles.
        tick(1'b1, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1, 16'h0200);
        check("st_cvalid", {31'h0, cpu_readdatavalid}, 32'h1);
        check("st_cdata",  cpu_readdata,               32'hCAFE0100);
        check("st_svalid", {31'h0, scan_rvalid},       32'h0);
        check("st2_wait0", {31'h0, cpu_waitrequest},   32'h1);
        for (int i = 1; i < 4; i++) begin
            tick(1'b1, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1, 16'h0200);
            check($sformatf("st2_wait%0d", i), {31'h0, cpu_waitrequest}, 32'h1);
        end
        tick(1'b1, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1, 16'h0200);
        check("st2_grant", {31'h0, cpu_waitrequest}, 32'h0);
        idle();
        check("st2_cdata", cpu_readdata, 32'hCAFE0101);

        // Back-to-back scan reads.
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'(k));
            check($sformatf("bb_gnt%0d", k),  {31'h0, scan_gnt},    32'h1);
            check($sformatf("bb_rv%0d", k),   {31'h0, scan_rvalid}, (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) check($sformatf("bb_data%0d", k - 1), scan_rdata, 32'hA0000000 + 32'(k - 1));
        end
        idle();
        check("bb_rv4",   {31'h0, scan_rvalid}, 32'h1);
        check("bb_data3", scan_rdata,           32'hA0000003);
        idle();
        check("bb_end",   {31'h0, scan_rvalid}, 32'h0);
        check("bb_hold",  scan_rdata,           32'hA0000003);

        // Out-of-range accesses.
        tick(1'b1, 1'b0, 16'd51200, 32'h0, 4'h0, 1'b0, 16'h0);
        check("oor_r_wait", {31'h0, cpu_waitrequest}, 32'h0);
        check("oor_r_cs",   {31'h0, ram_chipselect},  32'h0);
        idle();
        check("oor_r_valid", {31'h0, cpu_readdatavalid}, 32'h1);
        check("oor_r_data",  cpu_readdata,               32'h0);
        cpu_wr(16'hFFFF, 32'h12345678, 4'hF);
        check("oor_w_wait", {31'h0, cpu_waitrequest}, 32'h0);
        check("oor_w_cs",   {31'h0, ram_chipselect},  32'h0);
        check("oor_w_wr",   {31'h0, ram_write},       32'h0);
        tick(1'b1, 1'b0, 16'd51199, 32'h0, 4'h0, 1'b0, 16'h0);
        check("last_cs",    {31'h0, ram_chipselect},  32'h1);
        idle();

        // Reset arriving in the cycle after a scan read grant.
        tick(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b1, 16'h0001);
        check("mr_gnt", {31'h0, scan_gnt}, 32'h1);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        scan_req = 1'b0;
        #1;
        check("mr_svalid", {31'h0, scan_rvalid},       32'h0);
        check("mr_sdata",  scan_rdata,                 32'h0);
        check("mr_cdata",  cpu_readdata,               32'h0);
        check("mr_cvalid", {31'h0, cpu_readdatavalid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        check("mr_svalid2", {31'h0, scan_rvalid}, 32'h0);
        check("mr_sdata2",  scan_rdata,           32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
